imem_loader: RTL and testbench

Byte-stream writer that fills the MIPS instruction memory before execution. It accepts a framed byte stream (length, big-endian instruction bytes, XOR checksum) over a valid/ready handshake and assembles 32-bit words. It issues one write per word into the instruction memory's write port, at byte addresses matching the PC (`PC_OUT[7:0]`). It holds the processor in reset until a frame loads cleanly.

---
 rtl/imem_loader.sv | 115 +++++++++++
 tb/tb_imem_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the MIPS instruction memory: length byte, big-endian
// words, XOR checksum. Emits one write per assembled word and holds the CPU in reset until a clean frame.
module imem_loader #(
  parameter int WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        im_we,
  output logic [7:0]  im_waddr,
  output logic [31:0] im_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;

  localparam logic [8:0] MAX_LEN = 9'(WORDS);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_len;
  logic [7:0]  r_word_idx;
  logic [7:0]  r_csum;
  logic [1:0]  r_byte_cnt;
  logic [23:0] r_asm;

  logic w_xfer;
  logic w_start_ok;
  logic w_len_bad;
  logic w_last_word;

  assign w_xfer      = byte_valid & byte_ready;
  assign w_start_ok  = start & ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERR));
  assign w_len_bad   = (byte_data == 8'd0) | ({1'b0, byte_data} > MAX_LEN);
  assign w_last_word = (r_word_idx == (r_len - 8'd1));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (w_start_ok) w_next = S_LEN;
      S_LEN:  if (w_xfer) w_next = w_len_bad ? S_ERR : S_DATA;
      S_DATA: if (w_xfer && (r_byte_cnt == 2'd3) && w_last_word) w_next = S_CHK;
      S_CHK:  if (w_xfer) w_next = (byte_data == r_csum) ? S_DONE : S_ERR;
      default: w_next = S_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they change with the state itself.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cpu_hold   <= 1'b1;
    end else begin
      byte_ready <= (w_next == S_LEN) | (w_next == S_DATA) | (w_next == S_CHK);
      busy       <= (w_next == S_LEN) | (w_next == S_DATA) | (w_next == S_CHK);
      done       <= (w_next == S_DONE);
      err        <= (w_next == S_ERR);
      cpu_hold   <= (w_next != S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_len      <= 8'd0;
      r_word_idx <= 8'd0;
      r_csum     <= 8'd0;
      r_byte_cnt <= 2'd0;
      r_asm      <= 24'd0;
      im_we      <= 1'b0;
      im_waddr   <= 8'd0;
      im_wdata   <= 32'd0;
    end else begin
      im_we <= 1'b0;
      if (w_start_ok) begin
        r_word_idx <= 8'd0;
        r_byte_cnt <= 2'd0;
        r_csum     <= 8'd0;
      end
      if (w_xfer && (r_state == S_LEN)) begin
        r_len  <= byte_data;
        r_csum <= byte_data;
      end
      if (w_xfer && (r_state == S_DATA)) begin
        r_asm      <= {r_asm[15:0], byte_data};
        r_csum     <= r_csum ^ byte_data;
        r_byte_cnt <= r_byte_cnt + 2'd1;
        if (r_byte_cnt == 2'd3) begin
          im_we      <= 1'b1;
          im_wdata   <= {r_asm, byte_data};
          im_waddr   <= {r_word_idx[5:0], 2'b00};
          r_word_idx <= r_word_idx + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected writes are queued as frames are
// driven and matched by a monitor whenever im_we pulses.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n, start, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, im_we, cpu_hold, busy, done, err;
  logic [7:0]  im_waddr;
  logic [31:0] im_wdata;

  int n_checks = 0;
  int n_pass   = 0;

  logic [39:0] exp_q[$];
  logic [31:0] frame_words[64];
  logic [7:0]  last_addr = 8'h00;

  imem_loader #(.WORDS(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Scoreboard: every write pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      logic [39:0] exp;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: addr=%h data=%h, no write expected", im_waddr, im_wdata);
      end else begin
        exp = exp_q.pop_front();
        if ({im_waddr, im_wdata} !== exp)
          $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                   im_waddr, im_wdata, exp[39:32], exp[31:0]);
        else
          n_pass++;
      end
      last_addr = im_waddr;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
    int t = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    start      = with_start;
    while (byte_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      start = 1'b0;
      t++;
    end
    if (t >= 100) begin
      n_checks++;
      $display("FAIL send_byte_timeout: byte_ready=%b, expected 1 within 100 cycles", byte_ready);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    start      = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({byte_ready, busy, cpu_hold, done, err} !== 5'b11100)
      $display("FAIL start: {ready,busy,hold,done,err}=%b, expected 11100",
               {byte_ready, busy, cpu_hold, done, err});
    else n_pass++;
  endtask

  task automatic send_frame(input int n, input int gap, input bit bad, input int start_at);
    logic [7:0] cs;
    logic [7:0] b;
    int k = 0;
    cs = 8'(n);
    send_byte(8'(n), gap, 1'b0);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({8'(i * 4), frame_words[i]});
      for (int j = 0; j < 4; j++) begin
        b  = frame_words[i][31 - 8 * j -: 8];
        cs = cs ^ b;
        send_byte(b, gap, k == start_at);
        k++;
      end
    end
    if (bad) cs = cs ^ 8'h01;
    send_byte(cs, 0, 1'b0);
    n_checks++;
    if ({done, err, cpu_hold, busy, byte_ready} !== {~bad, bad, bad, 2'b00})
      $display("FAIL frame_end: {done,err,hold,busy,ready}=%b, expected %b",
               {done, err, cpu_hold, busy, byte_ready}, {~bad, bad, bad, 2'b00});
    else n_pass++;
  endtask

  task automatic check_reset_values(input string name);
    n_checks++;
    if ({byte_ready, im_we, im_waddr, im_wdata, cpu_hold, busy, done, err} !==
        {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0})
      $display("FAIL %s: ready=%b we=%b addr=%h data=%h hold=%b busy=%b done=%b err=%b, expected reset values",
               name, byte_ready, im_we, im_waddr, im_wdata, cpu_hold, busy, done, err);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("idle_after_reset");
  endtask

  task automatic load_example();
    frame_words[0] = 32'h20080005;
    frame_words[1] = 32'h8C090004;
  endtask

  task automatic test_clean_load();
    load_example();
    pulse_start();
    send_frame(2, 0, 1'b0, -1);
  endtask

  task automatic test_gapped_valid();
    pulse_start();
    send_frame(2, 3, 1'b0, -1);
  endtask

  task automatic test_bad_checksum();
    pulse_start();
    send_frame(2, 0, 1'b1, -1);
    pulse_start();
    send_frame(2, 0, 1'b0, -1);
  endtask

  task automatic test_length_bounds();
    logic [7:0] bad_len[2];
    bad_len[0] = 8'h00;
    bad_len[1] = 8'h41;
    for (int i = 0; i < 2; i++) begin
      pulse_start();
      send_byte(bad_len[i], 0, 1'b0);
      n_checks++;
      if ({err, byte_ready, done, cpu_hold, busy} !== 5'b10010)
        $display("FAIL len_%h: {err,ready,done,hold,busy}=%b, expected 10010",
                 bad_len[i], {err, byte_ready, done, cpu_hold, busy});
      else n_pass++;
    end
    for (int i = 0; i < 64; i++) frame_words[i] = $urandom;
    pulse_start();
    send_frame(64, 0, 1'b0, -1);
    n_checks++;
    if (last_addr !== 8'hFC)
      $display("FAIL full_last_addr: got %h, expected fc", last_addr);
    else n_pass++;
  endtask

  task automatic test_start_handling();
    load_example();
    pulse_start();
    send_frame(2, 0, 1'b0, 2);
    frame_words[0] = 32'hDEADBEEF;
    frame_words[1] = 32'h01234567;
    frame_words[2] = 32'hA5A55A5A;
    pulse_start();
    send_frame(3, 1, 1'b0, 5);
  endtask

  task automatic test_reset_mid_frame();
    int stray = 0;
    load_example();
    pulse_start();
    send_byte(8'h02, 0, 1'b0);
    exp_q.push_back({8'h00, frame_words[0]});
    for (int k = 0; k < 6; k++) send_byte(frame_words[k / 4][31 - 8 * (k % 4) -: 8], 0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_values("reset_mid_frame");
    rst_n = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'h8C;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (byte_ready !== 1'b0) stray++;
    end
    byte_valid = 1'b0;
    n_checks++;
    if (stray != 0) $display("FAIL post_reset_ready: byte_ready high %0d cycles, expected 0", stray);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_clean_load();
    test_gapped_valid();
    test_bad_checksum();
    test_length_bounds();
    test_start_handling();
    test_reset_mid_frame();
    repeat (4) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL pending_writes: %0d outstanding, expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
